// File: rtl/mips_wb_pkg.sv
// Shared types and widths for the MIPS write-back unit.
package mips_wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LINK = 2'd1,
        SRC_LOAD = 2'd2,
        SRC_RSVD = 2'd3
    } wb_source_t;

    typedef enum logic [2:0] {
        LT_LW   = 3'd0,
        LT_LB   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LH   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LWL  = 3'd5,
        LT_LWR  = 3'd6,
        LT_RSVD = 3'd7
    } load_type_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mips_load_formatter.sv
// Combinational load lane extraction / extension for little-endian memory words.
// LWL/LWR merging is built only when WB_PARTIAL_LOAD_EN is defined.
module mips_load_formatter
    import mips_wb_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  load_type_t        load_type,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] old_data,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] lane_word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign lane_word = word >> {offset, 3'b000};
    assign byte_sel  = lane_word[7:0];
    assign half_sel  = offset[1] ? word[31:16] : word[15:0];

`ifdef WB_PARTIAL_LOAD_EN
    logic [DATA_W-1:0] ones;
    logic [4:0]        lwl_shift;
    logic [4:0]        lwr_shift;

    assign ones      = '1;
    // 8*(3-offset) equals {~offset, 000} for a 2-bit offset
    assign lwl_shift = {~offset, 3'b000};
    assign lwr_shift = {offset, 3'b000};
`else
    logic unused_old;
    assign unused_old = ^old_data;
`endif

    always_comb begin
        result = word;
        case (load_type)
            LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  result = {{24{1'b0}}, byte_sel};
            LT_LH:   result = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  result = {{16{1'b0}}, half_sel};
`ifdef WB_PARTIAL_LOAD_EN
            LT_LWL:  result = (word << lwl_shift) | (old_data & ~(ones << lwl_shift));
            LT_LWR:  result = (word >> lwr_shift) | (old_data & ~(ones >> lwr_shift));
`endif
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mips_writeback_unit.sv
// Register-file write-side driver: accepts results, waits for load data, issues one write.
// Optional LWL/LWR merge: define WB_PARTIAL_LOAD_EN.
module mips_writeback_unit
    import mips_wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [1:0]        wb_source,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] link,
    input  logic [2:0]        load_type,
    input  logic [1:0]        byte_offset,
    input  logic [DATA_W-1:0] old_rt_data,
    input  logic              mem_waitrequest,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              write_enable,
    output logic [REG_W-1:0]  write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              busy
);

    wb_state_t         state, next_state;
    logic              accept, sample, commit_go;
    logic [REG_W-1:0]  dest_q, commit_dest;
    load_type_t        ltype_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] old_q, fmt_data, commit_data;

    mips_load_formatter u_fmt (
        .word      (mem_readdata),
        .load_type (ltype_q),
        .offset    (off_q),
        .old_data  (old_q),
        .result    (fmt_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wb_valid) begin
                    accept     = 1'b1;
                    next_state = (wb_source == SRC_LOAD) ? ST_WAIT_MEM : ST_COMMIT;
                end
            end
            ST_WAIT_MEM: begin
                if (!mem_waitrequest) begin
                    sample     = 1'b1;
                    next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    assign wb_ready = (state == ST_IDLE);

    // ALU/LINK results go straight into the output registers on acceptance;
    // loads are formatted on the edge that samples the memory word.
    always_comb begin
        commit_go   = 1'b0;
        commit_dest = dest_q;
        commit_data = fmt_data;
        if (accept && wb_source != SRC_LOAD) begin
            commit_go   = 1'b1;
            commit_dest = wb_dest;
            commit_data = (wb_source == SRC_LINK) ? link : alu_result;
        end else if (sample) begin
            commit_go = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_q  <= '0;
            ltype_q <= LT_LW;
            off_q   <= '0;
            old_q   <= '0;
        end else if (accept) begin
            dest_q  <= wb_dest;
            ltype_q <= load_type_t'(load_type);
            off_q   <= byte_offset;
            old_q   <= old_rt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_enable   <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            busy           <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            busy         <= (next_state != ST_IDLE);
            if (commit_go && commit_dest != '0) begin
                write_enable   <= 1'b1;
                write_register <= commit_dest;
                write_data     <= commit_data;
            end
        end
    end

endmodule

// File: doc/mips_writeback_unit.md
# mips_writeback_unit

Write-side driver for the MIPS register file: accepts completed instruction results from execute/memory, waits out data-memory stalls for loads, applies load byte-lane extraction and extension, and issues exactly one registered write per accepted request on the register file's `write_enable` / `write_register` / `write_data` port. It sits between the memory-access stage and `mipsregisterfile2`, and is the only agent that writes that port.

## Interface
- No parameters; widths fixed (32-bit data, 5-bit register index).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `wb_valid` in 1: result request present.
- `wb_ready` out 1: unit can accept a request this cycle.
- `wb_source` in 2: 0 ALU, 1 LINK, 2 LOAD, 3 reserved (treated as ALU).
- `wb_dest` in 5: destination register index.
- `alu_result` in 32: ALU result.
- `link` in 32: PC+8 for JAL/JALR/BxxAL.
- `load_type` in 3: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR; 7 treated as LW.
- `byte_offset` in 2: effective address bits [1:0].
- `old_rt_data` in 32: current value of dest register (LWL/LWR merge).
- `mem_waitrequest` in 1: data memory stall.
- `mem_readdata` in 32: data memory read word, little-endian lanes.
- `write_enable` out 1: register file write strobe.
- `write_register` out 5: register file write index.
- `write_data` out 32: register file write data.
- `busy` out 1: high in WAIT_MEM or COMMIT.

## Operation
- States: IDLE, WAIT_MEM, COMMIT.
- IDLE: `wb_ready`=1. On `wb_valid`: latch dest, source, load_type, byte_offset, old_rt_data, alu_result/link. ALU/LINK -> COMMIT. LOAD -> WAIT_MEM.
- WAIT_MEM: `wb_ready`=0. Each cycle with `mem_waitrequest`=0: latch `mem_readdata` -> COMMIT. Stays indefinitely while `mem_waitrequest`=1.
- COMMIT: drive `write_enable`=1 (unless dest 0), `write_register`, `write_data` for exactly one cycle; `wb_ready`=0; -> IDLE.
- Load formatting (lane = `byte_offset`): LB/LBU select byte lane, sign/zero extend to 32. LH/LHU select halfword at offset[1] (offset[0] ignored, no exception), sign/zero extend. LW whole word, offset ignored.
- LWL: lanes offset..0 of memory word fill result bytes 3..(3-offset); remaining low bytes from `old_rt_data`. LWR: lanes 3..offset fill result bytes (3-offset)..0; remaining high bytes from `old_rt_data`. Offset 3 LWL and offset 0 LWR equal LW.
- Dest 0: full handshake and state sequence run, `write_enable` stays 0.
- Requests never dropped: `wb_valid` while `wb_ready`=0 is ignored; upstream holds it.

## Timing
- Reset (async, any state): state IDLE; `write_enable`=0, `write_register`=0, `write_data`=0, `busy`=0, `wb_ready`=1 after release. Reset during WAIT_MEM/COMMIT abandons the write; no write issued.
- All outputs registered except `wb_ready` (decoded from state).
- ALU/LINK: accept edge N, write visible cycle N+1, RF updated edge N+2.
- LOAD, zero wait: accept N, WAIT_MEM N+1 samples data, COMMIT N+2. Each waitrequest cycle adds one.
- Throughput: one ALU/LINK result per 2 cycles; back-to-back acceptance on the cycle after COMMIT.
- `write_register`/`write_data` hold last values when `write_enable`=0.

## Configuration
- `WB_PARTIAL_LOAD_EN` defined: LWL/LWR merge as above, `old_rt_data` used.
- Undefined: load_type 5/6 handled as LW; `old_rt_data` unused.

## Structure
- Package `mips_wb_pkg`: `wb_source_t` enum, `load_type_t` enum, `wb_state_t` enum, width constants.
- One sub-module `mips_load_formatter`: combinational word + type + offset + old value -> 32-bit result.

## Test plan
- Reset mid-WAIT_MEM with waitrequest=1 -> write_enable 0, outputs 0, wb_ready 1 after release; next ALU write proceeds.
- ALU dest 28, result 10 -> one cycle write_enable=1, write_register=28, write_data=10; then LINK dest 31, link 0x00400008 -> write_data 0x00400008.
- LB offset 2, readdata 0x12_80_34_56 -> 0xFFFFFF80; LBU same -> 0x00000080; LH offset 2 -> 0x00001280 … readdata 0x8000_1234 -> 0xFFFF8000.
- LOAD with 3 waitrequest cycles, dest 5, readdata 0xDEADBEEF -> write exactly 4 cycles after WAIT_MEM entry, data 0xDEADBEEF, wb_ready 0 throughout.
- ALU dest 0 result 20 -> write_enable never asserted, state returns IDLE after 2 cycles.
- With `WB_PARTIAL_LOAD_EN`: LWL offset 1, mem 0xAABBCCDD, old 0x11223344 -> 0xCCDD3344; LWR offset 1 -> 0x11AABBCC; without macro both -> 0xAABBCCDD.
